// File: rtl/prog_loader.sv
// prog_loader: boot loader packing a byte stream into 32-bit words for imem.
// Holds cpu_rst until load completes. Optional: LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W      = 10,
  parameter int MAX_WORDS   = 1024,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W:0] MAXW =
    (ADDR_W+1)'(MAX_WORDS);
  localparam logic [HW-1:0] HLAST =
    HW'(HOLD_CYCLES - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    LOAD, HOLD, RUN, ERR, CSUM
  } state_t;
`else
  typedef enum logic [1:0] {
    LOAD, HOLD, RUN, ERR
  } state_t;
`endif

  state_t          state;
  logic [1:0]      idx;
  logic [31:0]     acc;
  logic [31:0]     nxt;
  logic [HW-1:0]   hcnt;
  logic            take;
  logic            full;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     sum;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign in_ready = (state == LOAD) ||
                    (state == CSUM);
`else
  assign in_ready = (state == LOAD);
`endif

  assign take = in_valid & in_ready;
  assign full = (word_cnt == MAXW);

  // Insert the incoming byte big-endian at the current byte index
  always_comb begin
    nxt = acc;
    unique case (idx)
      2'd0: nxt[31:24] = in_data;
      2'd1: nxt[23:16] = in_data;
      2'd2: nxt[15:8]  = in_data;
      2'd3: nxt[7:0]   = in_data;
      default: nxt = acc;
    endcase
  end

  // Loader FSM: packs, writes, holds the core in reset, then releases it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= LOAD;
      idx      <= 2'd0;
      acc      <= 32'h0;
      hcnt     <= '0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= 32'h0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      word_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum      <= 32'h0;
`endif
    end else begin
      im_we <= 1'b0;
      unique case (state)
        LOAD: begin
          if (take) begin
            if (full) begin
              state <= ERR;
              err   <= 1'b1;
            end else if (idx == 2'd3 || in_last) begin
              im_we    <= 1'b1;
              im_addr  <= word_cnt[ADDR_W-1:0];
              im_wdata <= nxt;
              word_cnt <= word_cnt + 1'b1;
              idx      <= 2'd0;
              acc      <= 32'h0;
`ifdef LOADER_CHECKSUM_EN
              sum      <= sum + nxt;
              if (in_last) begin
                state <= CSUM;
              end
`else
              if (in_last) begin
                state <= HOLD;
                hcnt  <= '0;
              end
`endif
            end else begin
              acc <= nxt;
              idx <= idx + 2'd1;
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (take) begin
            if (idx == 2'd3) begin
              idx <= 2'd0;
              acc <= 32'h0;
              if (nxt == sum) begin
                state <= HOLD;
                hcnt  <= '0;
              end else begin
                state <= ERR;
                err   <= 1'b1;
              end
            end else begin
              acc <= nxt;
              idx <= idx + 2'd1;
            end
          end
        end
`endif
        HOLD: begin
          if (hcnt == HLAST) begin
            cpu_rst <= 1'b0;
            done    <= 1'b1;
            state   <= RUN;
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        RUN: begin
          state <= RUN;
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed table-driven bench for prog_loader.
// Built with MAX_WORDS=2 so overflow is reachable in a short stream.
module tb_prog_loader;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;
  logic [AW:0]   word_cnt;

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_W(AW),
    .MAX_WORDS(2),
    .HOLD_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .cpu_rst(cpu_rst),
    .done(done),
    .err(err),
    .word_cnt(word_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int we_cyc = 0;
  int rel_cyc = 0;
  logic prev_cr = 1'b1;
  logic [31:0] wq[$];
  logic [AW-1:0] aq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor and cpu_rst release timestamp
  always @(negedge clk) begin
    if (im_we) begin
      wq.push_back(im_wdata);
      aq.push_back(im_addr);
      we_cyc = cyc;
    end
    if (prev_cr && !cpu_rst) rel_cyc = cyc;
    prev_cr = cpu_rst;
  end

  typedef struct {
    int          n;
    logic [71:0] b;
    logic        last;
    int          nw;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        eerr;
  } vec_t;

  vec_t tv[6];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = 8'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d,
                      input logic l);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=%b required=1",
               in_ready);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_sum(input logic [31:0] s);
    send(s[31:24], 1'b0);
    send(s[23:16], 1'b0);
    send(s[15:8], 1'b0);
    send(s[7:0], 1'b1);
  endtask

  task automatic wait_end(input int maxc);
    int t;
    t = 0;
    while (!(done || err) && t < maxc) begin
      @(negedge clk);
      t++;
    end
    if (!(done || err)) begin
      checks++;
      failures++;
      $display("FAIL wait_end actual=%b%b required=done_or_err",
               done, err);
    end
  endtask

  task automatic chk_writes(input string nm,
                            input int base,
                            input int nw,
                            input logic [31:0] w0,
                            input logic [31:0] w1);
    chk({nm, "_nwrites"}, 32'(wq.size() - base), 32'(nw));
    for (int k = 0; k < nw; k++) begin
      if (base + k < wq.size()) begin
        chk({nm, "_addr"}, 32'(aq[base+k]), 32'(k));
        chk({nm, "_data"}, wq[base+k], (k == 0) ? w0 : w1);
      end
    end
  endtask

  task automatic send_t1(input int gap);
    logic [63:0] p;
    p = 64'h2008000520090003;
    for (int j = 0; j < 8; j++) begin
      send(p[63-8*j -: 8], j == 7);
      if (gap != 0) idle();
    end
`ifdef LOADER_CHECKSUM_EN
    send_sum(32'h40110008);
`endif
    idle();
  endtask

  initial begin
    int base;
    int d;
    logic [71:0] bb;
    logic [31:0] s;

    tv[0] = '{8, {64'h2008000520090003, 8'h00}, 1'b1,
              2, 32'h20080005, 32'h20090003, 1'b0};
    tv[1] = '{5, {40'hAABBCCDDEE, 32'h0}, 1'b1,
              2, 32'hAABBCCDD, 32'hEE000000, 1'b0};
    tv[2] = '{9, 72'h010203040506070809, 1'b0,
              2, 32'h01020304, 32'h05060708, 1'b1};
    tv[3] = '{1, {8'h7F, 64'h0}, 1'b1,
              1, 32'h7F000000, 32'h0, 1'b0};
    tv[4] = '{3, {24'h123456, 48'h0}, 1'b1,
              1, 32'h12345600, 32'h0, 1'b0};
    tv[5] = '{6, {48'hDEADBEEFCAFE, 24'h0}, 1'b1,
              2, 32'hDEADBEEF, 32'hCAFE0000, 1'b0};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      do_reset();
      base = wq.size();
      bb = tv[i].b;
      for (int j = 0; j < tv[i].n; j++) begin
        send(bb[71-8*j -: 8], tv[i].last && (j == tv[i].n - 1));
      end
`ifdef LOADER_CHECKSUM_EN
      if (tv[i].last) begin
        s = tv[i].w0 + ((tv[i].nw > 1) ? tv[i].w1 : 32'h0);
        send_sum(s);
      end
`endif
      idle();
      wait_end(40);
      repeat (3) @(negedge clk);
      chk_writes($sformatf("v%0d", i), base, tv[i].nw,
                 tv[i].w0, tv[i].w1);
      chk($sformatf("v%0d_word_cnt", i), 32'(word_cnt),
          32'(tv[i].nw));
      chk($sformatf("v%0d_done", i), 32'(done),
          32'(!tv[i].eerr));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].eerr));
      chk($sformatf("v%0d_cpu_rst", i), 32'(cpu_rst),
          32'(tv[i].eerr));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h0);
    end

    // Asynchronous reset from the RUN state
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_im_we", 32'(im_we), 32'h0);
    chk("rst_im_addr", 32'(im_addr), 32'h0);
    chk("rst_im_wdata", im_wdata, 32'h0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_word_cnt", 32'(word_cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Release timing after the final write
    do_reset();
    base = wq.size();
    send_t1(0);
    wait_end(40);
    repeat (2) @(negedge clk);
    chk_writes("t1", base, 2, 32'h20080005, 32'h20090003);
`ifndef LOADER_CHECKSUM_EN
    d = rel_cyc - we_cyc;
    chk("t1_release_delay", 32'(d), 32'd4);
`endif
    chk("t1_done", 32'(done), 32'h1);

    // Abort mid-word, then a clean single word
    do_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    idle();
    rst = 1'b1;
    #1;
    chk("mid_rst_word_cnt", 32'(word_cnt), 32'h0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = wq.size();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_sum(32'h11223344);
`endif
    idle();
    wait_end(40);
    chk_writes("mid", base, 1, 32'h11223344, 32'h0);
    chk("mid_word_cnt", 32'(word_cnt), 32'h1);

    // Gapped valid gives identical writes; RUN ignores bytes
    do_reset();
    base = wq.size();
    send_t1(1);
    wait_end(40);
    repeat (2) @(negedge clk);
    chk_writes("gap", base, 2, 32'h20080005, 32'h20090003);
    base = wq.size();
    in_valid = 1'b1;
    in_data = 8'h55;
    in_last = 1'b1;
    repeat (6) @(negedge clk);
    idle();
    chk("run_nwrites", 32'(wq.size() - base), 32'h0);
    chk("run_word_cnt", 32'(word_cnt), 32'h2);
    chk("run_done", 32'(done), 32'h1);
    chk("run_cpu_rst", 32'(cpu_rst), 32'h0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum is terminal
    do_reset();
    s = 64'h0;
    for (int j = 0; j < 8; j++) begin
      bb = {64'h2008000520090003, 8'h0};
      send(bb[71-8*j -: 8], j == 7);
    end
    send_sum(32'h40110009);
    idle();
    wait_end(40);
    repeat (6) @(negedge clk);
    chk("csum_bad_err", 32'(err), 32'h1);
    chk("csum_bad_cpu_rst", 32'(cpu_rst), 32'h1);
    chk("csum_bad_done", 32'(done), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
